triangle_raster_multi: RTL and testbench
========================================

# triangle_raster_multi

Parametrised multi-triangle rasterisation unit for the pixel pipeline. Up to NUM_TRI screen-space triangles are loaded through a setup handshake that precomputes edge-function coefficients. A streamed pixel coordinate is then tested against every loaded triangle in a fixed-latency pipeline, producing a per-triangle coverage mask. Sits between triangle projection and the pixel shader/compositor, driven by the video timing hcount/vcount stream.

## Interface
- COORD_W, 11, unsigned coordinate width (x and y)
- NUM_TRI, 4, number of triangle slots (≥1)
- STRICT, 0, 0 = edge/vertex pixels covered (inclusive); 1 = only strictly interior pixels covered

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tri_valid  in  1  triangle command valid
- tri_ready  out  1  setup engine idle, command accepted when tri_valid & tri_ready
- tri_clear  in  1  with accepted command: invalidate tri_slot, no setup
- tri_slot  in  max(1,$clog2(NUM_TRI))  target slot
- tri_vertices  in  [2:0][1:0][COORD_W-1:0]  vertex i = {y=[i][1], x=[i][0]}, unsigned
- pix_valid  in  1  pixel coordinate valid (no backpressure)
- hcount  in  COORD_W  pixel x
- vcount  in  COORD_W  pixel y
- out_valid  out  1  result valid
- out_hcount, out_vcount  out  COORD_W each  coordinate matching result
- hit_mask  out  NUM_TRI  bit k = pixel covered by active slot k
- any_hit  out  1  OR of hit_mask
- slot_active  out  NUM_TRI  slot holds a valid, non-degenerate triangle

## Operation
- Edge k joins vertex k → vertex (k+1)%3. Coefficients: A=ay−by, B=bx−ax, C=ax·by−bx·ay; E(x,y)=A·x+B·y+C.
- Widths: A, B signed COORD_W+2; C and all E arithmetic signed E_W=2·COORD_W+4, operands zero-extended then sign-extended; no overflow possible.
- Setup FSM: IDLE → EDGE0 → EDGE1 → EDGE2 → COMMIT → IDLE.
  - tri_ready = (state==IDLE).
  - In IDLE, on accept: latch slot and vertices. If tri_clear, then slot_active[slot]←0 next cycle and stay IDLE; otherwise go to EDGE0.
  - EDGEk computes edge k into shadow registers using a single shared multiplier pair.
  - COMMIT: if C0+C1+C2==0 (degenerate, zero area), slot_active[slot]←0 and the table is unchanged. Otherwise all 3 edges are written to the table and slot_active[slot]←1.
- Reloading an active slot replaces it atomically at COMMIT; other slots are unaffected.
- Pixel pipeline, one pixel per cycle, evaluated for all slots in parallel:
  - S1 registers A·x, B·y, C and the active bit for every slot/edge from the table contents of that cycle.
  - S2 registers E.
  - S3 computes coverage. Both windings are accepted.
    - STRICT=0: covered if all three E≥0 or all three E≤0.
    - STRICT=1: covered if all three E>0 or all three E<0.
    - hit_mask[k] = covered & active.
- Coordinates travel alongside the data; pix_valid=0 cycles produce out_valid=0 and hold the other outputs.

## Timing
- Reset values: tri_ready=1 (state IDLE from the first reset cycle), out_valid=0, hit_mask=0, any_hit=0, out_hcount=out_vcount=0, slot_active=0, all pipeline valids 0.
- Coverage latency: pixel at cycle t → out_valid/hit_mask at t+3. Throughput 1 pixel/cycle.
- Setup: accept at cycle t, COMMIT at t+4, slot_active updated and tri_ready=1 at t+5. tri_ready is low for cycles t+1..t+4.
- Clear: accept at t → slot_active[slot]=0 at t+1, tri_ready stays 1.
- Commit/pixel boundary: a pixel sampled by S1 in the COMMIT cycle (t+4) sees the old slot contents. A pixel sampled at t+5 or later sees the new ones. No mixed-edge snapshots.
- Reset mid-setup aborts the load: FSM to IDLE, all slots inactive, in-flight pixels dropped.
- tri_valid while tri_ready=0 is ignored; the source must hold it until accepted.

## Test plan
- Load slot0 (10,10),(100,10),(10,100). Pixel (20,20) at t → hit_mask=0001, any_hit=1 at t+3. Pixel (100,100) → 0000.
- Same triangle, pixel (10,10) and (55,55) (vertex/hypotenuse): STRICT=0 → hit_mask[0]=1; STRICT=1 → 0. Reversed winding (10,10),(10,100),(100,10) gives identical results.
- Degenerate (0,0),(5,5),(10,10) into slot1 → slot_active[1]=0 at accept+5, pixel (5,5) → hit_mask[1]=0.
- Slot0 active; reload slot0 with (200,200),(300,200),(200,300) while streaming (20,20) every cycle → hits through the pixel sampled at accept+4, misses from the pixel sampled at accept+5. tri_ready low for exactly 4 cycles.
- Four overlapping triangles in slots 0..3, pixel inside all → 1111. tri_clear slot2 → 1011 for pixels sampled from clear+1.
- Assert rst during EDGE1 → tri_ready=1, slot_active=0, out_valid=0 the cycle after. A subsequent load completes normally.

Source files
------------

// File: rtl/triangle_raster_multi.sv
// Multi-slot triangle coverage tester: a setup FSM turns vertex triples into edge-function tables, and a pixel pipeline tests each pixel against every slot.
// Latency: pixel coverage in 3 cycles at 1 pixel/cycle. Setup takes 5 cycles from accept to slot_active (clear takes 1 cycle).
// Backpressure: tri_ready is low while a setup is in flight. Pixels have no backpressure.
// Ports: clk/rst (sync, active-high); tri_valid/tri_ready/tri_clear/tri_slot/tri_vertices form the setup command;
//        pix_valid/hcount/vcount carry the pixel stream; out_valid/out_hcount/out_vcount/hit_mask/any_hit carry the result;
//        slot_active flags the slots that hold a valid, non-degenerate triangle.
module triangle_raster_multi #(
  parameter int COORD_W = 11,
  parameter int NUM_TRI = 4,
  parameter int STRICT  = 0,
  localparam int SLOT_W = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tri_valid,
  output logic                             tri_ready,
  input  logic                             tri_clear,
  input  logic [SLOT_W-1:0]                tri_slot,
  input  logic [2:0][1:0][COORD_W-1:0]     tri_vertices,
  input  logic                             pix_valid,
  input  logic [COORD_W-1:0]               hcount,
  input  logic [COORD_W-1:0]               vcount,
  output logic                             out_valid,
  output logic [COORD_W-1:0]               out_hcount,
  output logic [COORD_W-1:0]               out_vcount,
  output logic [NUM_TRI-1:0]               hit_mask,
  output logic                             any_hit,
  output logic [NUM_TRI-1:0]               slot_active
);
  localparam int AB_W = COORD_W + 2;
  localparam int E_W  = 2 * COORD_W + 4;

  typedef enum logic [2:0] {S_IDLE, S_EDGE0, S_EDGE1, S_EDGE2, S_COMMIT} state_t;

  state_t                       state, edge_next_state;
  logic [SLOT_W-1:0]            ld_slot;
  logic [2:0][1:0][COORD_W-1:0] ld_vtx;
  logic signed [AB_W-1:0]       sh_a [3];
  logic signed [AB_W-1:0]       sh_b [3];
  logic signed [E_W-1:0]        sh_c [3];

  // ---------------- setup datapath: one edge per cycle ----------------
  logic [1:0] edge_sel, edge_nxt;

  always_comb begin
    edge_sel        = 2'd0;
    edge_nxt        = 2'd1;
    edge_next_state = S_EDGE1;
    case (state)
      S_EDGE1: begin edge_sel = 2'd1; edge_nxt = 2'd2; edge_next_state = S_EDGE2;  end
      S_EDGE2: begin edge_sel = 2'd2; edge_nxt = 2'd0; edge_next_state = S_COMMIT; end
      default: ;
    endcase
  end

  logic [COORD_W-1:0]     ax, ay, bx, by;
  logic signed [AB_W-1:0] edge_a, edge_b;
  logic signed [E_W-1:0]  mul_p, mul_q, edge_c;

  assign ax = ld_vtx[edge_sel][0];
  assign ay = ld_vtx[edge_sel][1];
  assign bx = ld_vtx[edge_nxt][0];
  assign by = ld_vtx[edge_nxt][1];

  assign edge_a = $signed(AB_W'(ay)) - $signed(AB_W'(by));
  assign edge_b = $signed(AB_W'(bx)) - $signed(AB_W'(ax));
  // The single multiplier pair is time-shared across the three edge cycles.
  assign mul_p  = $signed(E_W'(ax)) * $signed(E_W'(by));
  assign mul_q  = $signed(E_W'(bx)) * $signed(E_W'(ay));
  assign edge_c = mul_p - mul_q;

  // Sum of the three C terms is twice the signed area; zero means a degenerate triangle.
  logic signed [E_W-1:0] c_sum;
  logic                  degenerate;
  logic                  ld_slot_ok;
  assign c_sum      = sh_c[0] + sh_c[1] + sh_c[2];
  assign degenerate = (c_sum == '0);
  assign ld_slot_ok = (int'(ld_slot) < NUM_TRI);

  assign tri_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      slot_active <= '0;
      ld_slot     <= '0;
      ld_vtx      <= '0;
      for (int e = 0; e < 3; e++) begin
        sh_a[e] <= '0;
        sh_b[e] <= '0;
        sh_c[e] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (tri_valid) begin
            ld_slot <= tri_slot;
            ld_vtx  <= tri_vertices;
            if (tri_clear) begin
              if (int'(tri_slot) < NUM_TRI) slot_active[tri_slot] <= 1'b0;
            end else begin
              state <= S_EDGE0;
            end
          end
        end
        S_EDGE0, S_EDGE1, S_EDGE2: begin
          sh_a[edge_sel] <= edge_a;
          sh_b[edge_sel] <= edge_b;
          sh_c[edge_sel] <= edge_c;
          state          <= edge_next_state;
        end
        S_COMMIT: begin
          if (ld_slot_ok) slot_active[ld_slot] <= !degenerate;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- coefficient table ----------------
  // Written in one edge at COMMIT, so the pixel pipeline never sees a mix of old and new edges.
  logic signed [AB_W-1:0] tbl_a [NUM_TRI][3];
  logic signed [AB_W-1:0] tbl_b [NUM_TRI][3];
  logic signed [E_W-1:0]  tbl_c [NUM_TRI][3];

  always_ff @(posedge clk) begin
    if (!rst && state == S_COMMIT && !degenerate && ld_slot_ok) begin
      for (int e = 0; e < 3; e++) begin
        tbl_a[ld_slot][e] <= sh_a[e];
        tbl_b[ld_slot][e] <= sh_b[e];
        tbl_c[ld_slot][e] <= sh_c[e];
      end
    end
  end

  // ---------------- pixel pipeline ----------------
  logic signed [E_W-1:0] pix_x, pix_y;
  assign pix_x = E_W'(hcount);
  assign pix_y = E_W'(vcount);

  logic signed [E_W-1:0] s1_ax [NUM_TRI][3];
  logic signed [E_W-1:0] s1_by [NUM_TRI][3];
  logic signed [E_W-1:0] s1_c  [NUM_TRI][3];
  logic signed [E_W-1:0] s2_e  [NUM_TRI][3];
  logic [NUM_TRI-1:0]    s1_act, s2_act;
  logic                  s1_vld, s2_vld;
  logic [COORD_W-1:0]    s1_h, s1_v, s2_h, s2_v;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_TRI; k++) begin
      for (int e = 0; e < 3; e++) begin
        s1_ax[k][e] <= E_W'(tbl_a[k][e]) * pix_x;
        s1_by[k][e] <= E_W'(tbl_b[k][e]) * pix_y;
        s1_c[k][e]  <= tbl_c[k][e];
        s2_e[k][e]  <= s1_ax[k][e] + s1_by[k][e] + s1_c[k][e];
      end
    end
    s1_h <= hcount;
    s1_v <= vcount;
    s2_h <= s1_h;
    s2_v <= s1_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_act <= '0;
      s2_act <= '0;
    end else begin
      s1_vld <= pix_valid;
      s2_vld <= s1_vld;
      s1_act <= slot_active;
      s2_act <= s1_act;
    end
  end

  // Coverage accepts either winding: all edges on one side, with zero counted as inside unless STRICT.
  logic [NUM_TRI-1:0] covered;

  always_comb begin
    covered = '0;
    for (int k = 0; k < NUM_TRI; k++) begin
      logic [2:0] neg, zer;
      neg = '0;
      zer = '0;
      for (int e = 0; e < 3; e++) begin
        neg[e] = s2_e[k][e][E_W-1];
        zer[e] = (s2_e[k][e] == '0);
      end
      if (STRICT != 0) covered[k] = (&(~neg & ~zer)) | (&neg);
      else             covered[k] = (~|neg) | (&(neg | zer));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_hcount <= '0;
      out_vcount <= '0;
      hit_mask   <= '0;
      any_hit    <= 1'b0;
    end else begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_hcount <= s2_h;
        out_vcount <= s2_v;
        hit_mask   <= covered & s2_act;
        any_hit    <= |(covered & s2_act);
      end
    end
  end

endmodule

// File: tb/tb_triangle_raster_multi.sv
module tb_triangle_raster_multi;
  localparam int CW = 11;
  localparam int NT = 4;
  typedef logic [2:0][1:0][CW-1:0] vtx_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tri_valid = 1'b0;
  logic          tri_clear = 1'b0;
  logic [1:0]    tri_slot = '0;
  vtx_t          tri_vertices = '0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] hcount = '0;
  logic [CW-1:0] vcount = '0;

  logic          tri_ready, out_valid, any_hit;
  logic [CW-1:0] out_hcount, out_vcount;
  logic [NT-1:0] hit_mask, slot_active;

  logic          tri_ready_s, out_valid_s, any_hit_s;
  logic [CW-1:0] out_hcount_s, out_vcount_s;
  logic [NT-1:0] hit_mask_s, slot_active_s;

  always #5 clk = ~clk;

  triangle_raster_multi #(.COORD_W(CW), .NUM_TRI(NT), .STRICT(0)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_clear(tri_clear),
    .tri_slot(tri_slot), .tri_vertices(tri_vertices), .pix_valid(pix_valid), .hcount(hcount),
    .vcount(vcount), .out_valid(out_valid), .out_hcount(out_hcount), .out_vcount(out_vcount),
    .hit_mask(hit_mask), .any_hit(any_hit), .slot_active(slot_active));

  triangle_raster_multi #(.COORD_W(CW), .NUM_TRI(NT), .STRICT(1)) dut_s (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready_s), .tri_clear(tri_clear),
    .tri_slot(tri_slot), .tri_vertices(tri_vertices), .pix_valid(pix_valid), .hcount(hcount),
    .vcount(vcount), .out_valid(out_valid_s), .out_hcount(out_hcount_s), .out_vcount(out_vcount_s),
    .hit_mask(hit_mask_s), .any_hit(any_hit_s), .slot_active(slot_active_s));

  int checks = 0;
  int failures = 0;

  logic          rdy_log [16];
  logic [NT-1:0] m_log   [16];
  int            rdy_low;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vtx_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2);
    vtx_t v;
    v[0][0] = CW'(x0); v[0][1] = CW'(y0);
    v[1][0] = CW'(x1); v[1][1] = CW'(y1);
    v[2][0] = CW'(x2); v[2][1] = CW'(y2);
    return v;
  endfunction

  // Accept one setup command and count ready-low cycles until it completes.
  task automatic load(input string tag, input int slot, input vtx_t v);
    int n;
    n = 0;
    tri_valid = 1'b1; tri_clear = 1'b0; tri_slot = 2'(slot); tri_vertices = v;
    tick();
    tri_valid = 1'b0;
    while (!tri_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_busy"}, n, 4);
  endtask

  // Drive one pixel and check the result three cycles later, on both STRICT variants.
  task automatic probe(input string tag, input int x, input int y,
                       input logic [NT-1:0] exp, input logic [NT-1:0] exp_s);
    pix_valid = 1'b1; hcount = CW'(x); vcount = CW'(y);
    tick();
    pix_valid = 1'b0;
    tick();
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_mask"}, hit_mask, exp);
    check({tag, "_mask_strict"}, hit_mask_s, exp_s);
    check({tag, "_any"}, any_hit, (exp != 0) ? 1 : 0);
    check({tag, "_xy"}, {out_hcount, out_vcount}, {CW'(x), CW'(y)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_ready", tri_ready, 1);
    check("rst_vld", out_valid, 0);
    check("rst_mask", hit_mask, 0);
    check("rst_any", any_hit, 0);
    check("rst_active", slot_active, 0);
    check("rst_xy", {out_hcount, out_vcount}, 0);
    rst = 1'b0;
    tick();

    // Basic triangle in slot 0, then the same triangle with reversed winding.
    load("t0", 0, mk(10, 10, 100, 10, 10, 100));
    check("t0_active", slot_active, 4'b0001);
    probe("t0_in", 20, 20, 4'b0001, 4'b0001);
    probe("t0_out", 100, 100, 4'b0000, 4'b0000);
    probe("t0_vertex", 10, 10, 4'b0001, 4'b0000);
    probe("t0_hyp", 55, 55, 4'b0001, 4'b0000);
    tick();
    check("hold_vld", out_valid, 0);
    check("hold_mask", hit_mask, 4'b0001);

    load("rev", 0, mk(10, 10, 10, 100, 100, 10));
    probe("rev_in", 20, 20, 4'b0001, 4'b0001);
    probe("rev_out", 100, 100, 4'b0000, 4'b0000);
    probe("rev_vertex", 10, 10, 4'b0001, 4'b0000);
    probe("rev_hyp", 55, 55, 4'b0001, 4'b0000);

    // Zero-area triangle must leave its slot inactive.
    load("degen", 1, mk(0, 0, 5, 5, 10, 10));
    check("degen_active", slot_active, 4'b0001);
    probe("degen_px", 5, 5, 4'b0000, 4'b0000);

    // Reload slot 0 while streaming (20,20); accept at cycle 4, commit at cycle 8.
    rdy_low = 0;
    pix_valid = 1'b1; hcount = CW'(20); vcount = CW'(20);
    tri_clear = 1'b0; tri_slot = 2'd0; tri_vertices = mk(200, 200, 300, 200, 200, 300);
    for (int c = 0; c < 16; c++) begin
      tri_valid = (c == 4);
      rdy_log[c] = tri_ready;
      m_log[c] = hit_mask;
      if (!tri_ready) rdy_low++;
      tick();
    end
    tri_valid = 1'b0; pix_valid = 1'b0;
    check("reload_rdy_low", rdy_low, 4);
    check("reload_rdy_acc", rdy_log[4], 1);
    check("reload_rdy_busy", rdy_log[5], 0);
    check("reload_rdy_back", rdy_log[9], 1);
    check("reload_old_hit", m_log[11], 4'b0001);
    check("reload_new_miss", m_log[12], 4'b0000);
    check("reload_active", slot_active, 4'b0001);

    // Four overlapping triangles, then clear slot 2.
    load("q0", 0, mk(0, 0, 400, 0, 0, 400));
    load("q1", 1, mk(10, 10, 10, 300, 300, 10));
    load("q2", 2, mk(5, 0, 300, 5, 5, 300));
    load("q3", 3, mk(0, 0, 200, 0, 0, 200));
    check("quad_active", slot_active, 4'b1111);
    probe("quad_all", 50, 50, 4'b1111, 4'b1111);
    tri_valid = 1'b1; tri_clear = 1'b1; tri_slot = 2'd2;
    tick();
    tri_valid = 1'b0; tri_clear = 1'b0;
    check("clr_ready", tri_ready, 1);
    check("clr_active", slot_active, 4'b1011);
    probe("clr_px", 50, 50, 4'b1011, 4'b1011);

    // Reset while the setup FSM is in EDGE1, with pixels in flight.
    pix_valid = 1'b1; hcount = CW'(20); vcount = CW'(20);
    tri_valid = 1'b1; tri_slot = 2'd1; tri_vertices = mk(10, 10, 100, 10, 10, 100);
    tick();
    tri_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mrst_ready", tri_ready, 1);
    check("mrst_active", slot_active, 0);
    check("mrst_vld", out_valid, 0);
    check("mrst_mask", hit_mask, 0);
    rst = 1'b0; pix_valid = 1'b0;
    tick(); tick();
    check("mrst_drain", out_valid, 0);
    load("after", 1, mk(10, 10, 100, 10, 10, 100));
    check("after_active", slot_active, 4'b0010);
    probe("after_px", 20, 20, 4'b0010, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
